// File: rtl/led_sequencer.sv
// 10-LED bar arbiter: live stage thermometer, level-up chase and game-over blink,
// sequenced by a four-state FSM and a shared animation tick timer.
module led_sequencer #(
    parameter int TICK_DIV  = 5_000_000,
    parameter int CHASE_LEN = 10
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [31:0] stage,
    input  logic        stage_up,
    input  logic        start,
    input  logic        game_over,
    output logic [9:0]  leds,
    output logic        busy,
    output logic [1:0]  mode
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_BAR   = 2'b01;
    localparam logic [1:0] S_CHASE = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pos_q, pos_d;
    logic          blink_q, blink_d;
    logic [9:0]    leds_q, leds_d;

    logic          counting, tick, last_pos, entry, restart;
    logic [3:0]    sh;
    logic [9:0]    bar;

    assign counting = (state_q == S_CHASE) || (state_q == S_OVER);
    assign tick     = counting && (cnt_q == CW'(TICK_DIV - 1));
    assign last_pos = (pos_q == 4'(CHASE_LEN - 1));

    // Priority: game_over, then start, then stage_up, then chase completion.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (game_over) begin
            if (state_q != S_OVER) state_d = S_OVER;
        end else if (state_q == S_OVER) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_BAR;
        end else if (stage_up && state_q == S_BAR) begin
            state_d = S_CHASE;
        end else if (stage_up && state_q == S_CHASE) begin
            restart = 1'b1;
        end else if (state_q == S_CHASE && tick && last_pos) begin
            state_d = S_BAR;
        end
    end

    assign entry = (state_d != state_q);

    always_comb begin
        cnt_d   = '0;
        pos_d   = pos_q;
        blink_d = blink_q;
        if (entry || restart) begin
            pos_d   = '0;
            blink_d = 1'b1;
        end else begin
            if (counting && !tick) cnt_d = cnt_q + 1'b1;
            if (tick && state_q == S_CHASE) pos_d = pos_q + 4'd1;
            if (tick && state_q == S_OVER) blink_d = ~blink_q;
        end
    end

    // Thermometer: min(stage,9)+1 low bits set.
    assign sh  = 4'd9 - stage[3:0];
    assign bar = (stage > 32'd9) ? 10'h3FF : (10'h3FF >> sh);

    always_comb begin
        leds_d = 10'h3FF;
        case (state_q)
            S_IDLE:  leds_d = 10'h3FF;
            S_BAR:   leds_d = bar;
            S_CHASE: leds_d = 10'd1 << pos_q;
            S_OVER:  leds_d = {10{blink_q}};
            default: leds_d = 10'h3FF;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            blink_q <= 1'b1;
            leds_q  <= 10'h3FF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            blink_q <= blink_d;
            leds_q  <= leds_d;
        end
    end

    assign leds = leds_q;
    assign mode = state_q;
    assign busy = (state_q == S_CHASE);
endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed scenarios plus random traffic checked against
// a model that tracks each state by its age in cycles since entry.
module tb_led_sequencer;
    localparam int TD = 4;
    localparam int CL = 10;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] stage = '0;
    logic        stage_up = 1'b0, start = 1'b0, game_over = 1'b0;
    logic [9:0]  leds;
    logic        busy;
    logic [1:0]  mode;

    int errors = 0;
    int checks = 0;

    // model: 0 IDLE, 1 BAR, 2 CHASE, 3 OVER; age = cycles since entry/restart
    int         m_st = 0;
    int         m_age = 0;
    logic [9:0] m_leds = 10'h3FF;

    always #5 clk = ~clk;

    led_sequencer #(.TICK_DIV(TD), .CHASE_LEN(CL)) dut (
        .clk(clk), .resetN(resetN), .stage(stage), .stage_up(stage_up),
        .start(start), .game_over(game_over), .leds(leds), .busy(busy), .mode(mode)
    );

    function automatic logic [9:0] m_disp(input int st, input int age, input logic [31:0] stg);
        logic [9:0] r;
        r = 10'h3FF;
        case (st)
            1: r = (stg >= 32'd9) ? 10'h3FF : 10'((1 << (stg + 1)) - 1);
            2: r = 10'(1 << (age / TD));
            3: r = (((age / TD) % 2) == 0) ? 10'h3FF : 10'h000;
            default: r = 10'h3FF;
        endcase
        return r;
    endfunction

    task automatic cyc();
        int  nst;
        bit  rs;
        @(posedge clk);
        if (resetN) begin
            m_leds = m_disp(m_st, m_age, stage);
            nst = m_st;
            rs  = 0;
            if (game_over) begin
                if (m_st != 3) nst = 3;
            end else if (m_st == 3) nst = 0;
            else if (start) nst = 1;
            else if (stage_up && m_st == 1) nst = 2;
            else if (stage_up && m_st == 2) rs = 1;
            else if (m_st == 2 && m_age == CL * TD - 1) nst = 1;
            if (nst != m_st || rs) m_age = 0;
            else if (m_st >= 2) m_age++;
            m_st = nst;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic go, input logic st, input logic up);
        game_over = go; start = st; stage_up = up;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (leds !== 10'h3FF) begin errors++; $display("FAIL reset_leds got=%h exp=3ff", leds); end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=00", mode); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        resetN = 1'b1;
        drive(0, 0, 1);
        repeat (3) cyc();
        drive(0, 0, 0);
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_hold_idle got=%b exp=00", mode); end
    endtask

    task automatic test_thermometer();
        logic [31:0] sv [5] = '{32'd0, 32'd5, 32'd9, 32'd40, 32'hFFFF_FFFF};
        logic [9:0]  ev [5] = '{10'h001, 10'h03F, 10'h3FF, 10'h3FF, 10'h3FF};
        drive(0, 1, 0); cyc(); drive(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            stage = sv[i];
            cyc();
            checks++; if (leds !== ev[i]) begin errors++; $display("FAIL therm stage=%h got=%h exp=%h", sv[i], leds, ev[i]); end
            checks++; if (leds !== m_leds) begin errors++; $display("FAIL therm_model stage=%h got=%h exp=%h", sv[i], leds, m_leds); end
        end
    endtask

    task automatic test_chase();
        stage = 32'd3;
        drive(0, 0, 1); cyc(); drive(0, 0, 0);
        checks++; if (mode !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL chase_entry got mode=%b busy=%b exp 10/1", mode, busy); end
        for (int i = 1; i <= 41; i++) begin
            cyc();
            if (i <= 40) begin
                checks++;
                if (leds !== 10'(1 << ((i - 1) / TD))) begin errors++; $display("FAIL chase_pos cyc=%0d got=%h exp=%h", i, leds, 10'(1 << ((i - 1) / TD))); end
            end
            checks++; if (mode !== 2'(m_st)) begin errors++; $display("FAIL chase_mode cyc=%0d got=%b exp=%0d", i, mode, m_st); end
        end
        checks++; if (mode !== 2'b01 || leds !== 10'h00F) begin errors++; $display("FAIL chase_return got mode=%b leds=%h exp 01/00f", mode, leds); end
    endtask

    task automatic test_restart_abort();
        drive(0, 0, 1); cyc(); drive(0, 0, 0);
        repeat (25) cyc();
        drive(0, 0, 1); cyc(); drive(0, 0, 0);
        cyc();
        checks++; if (leds !== 10'h001) begin errors++; $display("FAIL restart_leds got=%h exp=001", leds); end
        for (int i = 2; i <= 41; i++) begin
            cyc();
            checks++; if (mode !== 2'(m_st) || leds !== m_leds) begin errors++; $display("FAIL restart_run cyc=%0d got=%b/%h exp=%0d/%h", i, mode, leds, m_st, m_leds); end
            checks++; if (mode !== ((i < 40) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL restart_len cyc=%0d got=%b", i, mode); end
        end
        drive(0, 0, 1); cyc(); drive(0, 0, 0);
        repeat (13) cyc();
        drive(0, 1, 0); cyc(); drive(0, 0, 0);
        checks++; if (mode !== 2'b01 || busy !== 1'b0) begin errors++; $display("FAIL abort got mode=%b busy=%b exp 01/0", mode, busy); end
    endtask

    task automatic test_game_over();
        drive(0, 0, 1); cyc(); drive(0, 0, 0);
        repeat (6) cyc();
        drive(1, 0, 0); cyc();
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL over_entry got=%b exp=11", mode); end
        for (int i = 1; i <= 20; i++) begin
            drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc();
            checks++; if (leds !== ((((i - 1) / TD) % 2 == 0) ? 10'h3FF : 10'h000)) begin errors++; $display("FAIL over_blink cyc=%0d got=%h", i, leds); end
            checks++; if (mode !== 2'b11) begin errors++; $display("FAIL over_hold cyc=%0d got=%b exp=11", i, mode); end
        end
        drive(0, 0, 0); cyc();
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL over_exit got=%b exp=00", mode); end
        cyc();
        checks++; if (leds !== 10'h3FF) begin errors++; $display("FAIL over_exit_leds got=%h exp=3ff", leds); end
    endtask

    task automatic test_priority();
        drive(0, 1, 0); cyc();
        drive(1, 1, 1); cyc();
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL prio_all got=%b exp=11", mode); end
        drive(0, 0, 0); cyc();
        drive(0, 1, 0); cyc();
        drive(0, 0, 1); cyc();
        drive(0, 1, 1); cyc(); drive(0, 0, 0);
        checks++; if (mode !== 2'b01 || busy !== 1'b0) begin errors++; $display("FAIL prio_start_up got mode=%b busy=%b exp 01/0", mode, busy); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1); cyc(); drive(0, 0, 0);
        repeat (9) cyc();
        resetN = 1'b0;
        #1;
        m_st = 0; m_age = 0; m_leds = 10'h3FF;
        checks++; if (leds !== 10'h3FF || mode !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid got leds=%h mode=%b busy=%b exp 3ff/00/0", leds, mode, busy); end
        @(negedge clk);
        resetN = 1'b1;
        repeat (50) cyc();
        checks++; if (leds !== 10'h3FF || mode !== 2'b00) begin errors++; $display("FAIL reset_no_resume got leds=%h mode=%b", leds, mode); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
            start    = ($urandom_range(0, 29) == 0);
            stage_up = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 7) == 0)
                stage = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
            cyc();
            checks++; if (leds !== m_leds) begin errors++; $display("FAIL rand_leds cyc=%0d got=%h exp=%h", i, leds, m_leds); end
            checks++; if (mode !== 2'(m_st)) begin errors++; $display("FAIL rand_mode cyc=%0d got=%b exp=%0d", i, mode, m_st); end
            checks++; if (busy !== (m_st == 2)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%0d", i, busy, m_st == 2); end
        end
        drive(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_thermometer();
        test_chase();
        test_restart_abort();
        test_game_over();
        test_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Owns the 10-LED bar and shares it among three display requesters: the live stage thermometer, a level-up chase animation, and a game-over blink. It sits between the game-logic outputs (`stage`, `stage_up`, `game_over`, `start`) and the board LED pins. It sequences the bar with a four-state FSM and a tick timer.

## Interface
- TICK_DIV, 5_000_000: clk cycles per animation tick; minimum 2. This is 0.1 s at 50 MHz.
- CHASE_LEN, 10: number of chase ticks; range 1..10.
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- stage  in  32  current game stage, unsigned
- stage_up  in  1  one-cycle pulse: stage advanced
- start  in  1  one-cycle pulse: new game started
- game_over  in  1  level: high while the game is over
- leds  out  10  registered LED drive; bit 0 is the leftmost LED of the bar
- busy  out  1  high while in CHASE
- mode  out  2  current state: 00 IDLE, 01 BAR, 10 CHASE, 11 OVER

## Operation
- The FSM has four states: IDLE, BAR, CHASE, OVER.
- **Input priority**, evaluated every cycle: game_over, then start, then stage_up.
- **OVER entry:** game_over high in IDLE, BAR or CHASE → OVER.
- **OVER exit:** OVER with game_over low → IDLE.
- **start:** start in IDLE, BAR or CHASE → BAR. This aborts any chase. start is ignored in OVER.
- **stage_up in BAR:** → CHASE with pos=0.
- **stage_up in CHASE:** restarts the chase (pos=0, tick counter cleared).
- **stage_up elsewhere:** ignored in IDLE and OVER.
- **CHASE completion:** after the tick that occurs with pos=CHASE_LEN-1, → BAR.
- **IDLE display:** leds = 10'b1111111111.
- **BAR display:** thermometer with the low min(stage,9)+1 bits set.
  - stage=0 → 10'b0000000001; stage=3 → 10'b0000001111.
  - stage≥9 (any 32-bit value) → all ones.
  - The bar tracks `stage` live every cycle.
- **CHASE display:** leds = one-hot, bit pos. pos increments by 1 per tick.
- **OVER display:** all ones on entry, then bitwise inverted every tick (all-on/all-off blink).
- **Tick counter:** runs 0..TICK_DIV-1. A tick is the cycle where counter=TICK_DIV-1; the counter then wraps to 0.
  - The counter clears to 0 on every state entry and on a chase restart.
  - It counts only in CHASE and OVER; it holds 0 in IDLE and BAR.
- **busy** = (mode==10).
- **Reset values:**
  - state IDLE, mode 00, busy 0.
  - leds 10'b1111111111.
  - pos 0, tick counter 0, blink phase = on.
- **Reset mid-animation:** asserting resetN low at any time forces the reset values asynchronously. No animation resumes after reset.

## Timing
- An input sampled at clk edge k updates state, mode and busy at edge k.
- leds is registered from state and counters, so it reflects the new state at edge k+1. Latency from input pulse to leds is 2 cycles.
- One CHASE lasts exactly CHASE_LEN×TICK_DIV cycles from the entry edge to the return to BAR. Each LED position is held TICK_DIV cycles.
- OVER blink half-period is TICK_DIV cycles.
- **Simultaneous events:**
  - start and stage_up in the same cycle in CHASE → BAR; stage_up is dropped.
  - game_over with anything → OVER.
  - stage_up coinciding with the final chase tick → chase restarts; the FSM does not go to BAR.
- stage is not registered inside the block. Changes appear on leds one cycle later, in BAR only.

## Test plan
Run all scenarios with TICK_DIV=4, CHASE_LEN=10.
1. **Reset:** resetN low mid-CHASE → leds=10'h3FF, mode=00, busy=0 immediately. After release, the block holds IDLE.
2. **Thermometer:** pulse start, then sweep stage 0,5,9,40,0xFFFFFFFF → leds 0x001, 0x03F, 0x3FF, 0x3FF, 0x3FF, each one cycle after the stage change.
3. **Chase:** in BAR, pulse stage_up → mode=10 next edge.
   - leds=0x001 for 4 cycles, then 0x002 … 0x200.
   - Back to BAR 40 cycles after entry, showing the thermometer.
4. **Chase restart/abort:**
   - stage_up at pos=6 → leds returns to 0x001 and the full 40 cycles rerun.
   - start at pos=3 → BAR immediately, busy=0.
5. **Game over:** raise game_over during CHASE → mode=11.
   - leds alternates 0x3FF/0x000 every 4 cycles.
   - stage_up and start are ignored while game_over is high.
   - Drop game_over → IDLE, leds=0x3FF.
6. **Priority:** game_over, start and stage_up high in the same cycle from BAR → OVER. start+stage_up together from CHASE → BAR.
